// File: rtl/weighted_ballot_counter_pkg.sv
// Shared definitions for the weighted ballot counter.
//   state_t  : session FSM encoding (IDLE / OPEN / CLOSED)
//   DEF_*    : default voter counts, weights, result width and threshold
//   sat_add  : unsigned add clamped to an upper limit
package weighted_ballot_counter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_OPEN   = 2'd1,
    ST_CLOSED = 2'd2
  } state_t;

  localparam int unsigned DEF_N_NP   = 32;
  localparam int unsigned DEF_N_VIP  = 8;
  localparam int unsigned DEF_N_VVIP = 1;
  localparam int unsigned DEF_W_NP   = 1;
  localparam int unsigned DEF_W_VIP  = 4;
  localparam int unsigned DEF_W_VVIP = 16;
  localparam int unsigned DEF_RES_W  = 8;
  localparam int unsigned DEF_THRESH = 41;

  function automatic int unsigned sat_add(input int unsigned a,
                                          input int unsigned b,
                                          input int unsigned limit);
    int unsigned s;
    s = a + b;
    return (s > limit) ? limit : s;
  endfunction

endpackage

// File: rtl/weighted_ballot_counter_if.sv
// Ballot bus between the voting pins and the counter.
//   master : drives start, close and the per-voter vote pulses np/vip/vvip,
//            observes result, open, decided, pass
//   slave  : the counter side of the same signals
interface weighted_ballot_counter_if #(
  parameter int unsigned N_NP   = 32,
  parameter int unsigned N_VIP  = 8,
  parameter int unsigned N_VVIP = 1,
  parameter int unsigned RES_W  = 8
);
  logic              start;
  logic              close;
  logic [N_NP-1:0]   np;
  logic [N_VIP-1:0]  vip;
  logic [N_VVIP-1:0] vvip;
  logic [RES_W-1:0]  result;
  logic              open;
  logic              decided;
  logic              pass;

  modport master (
    output start, close, np, vip, vvip,
    input  result, open, decided, pass
  );

  modport slave (
    input  start, close, np, vip, vvip,
    output result, open, decided, pass
  );
endinterface

// File: rtl/weighted_ballot_counter_ballot_bank.sv
// One voter class: N ballot registers plus their weighted popcount.
// Build option CHANGE_VOTE_EN: votes toggle (second pulse withdraws);
// otherwise votes are sticky for the rest of the session.
//   clk, reset : clock, synchronous active-low reset
//   clear      : wipe all ballots (session start)
//   capture    : accept vote pulses this cycle
//   votes      : per-voter vote pulses
//   sum        : W * popcount of the registered ballots
//   sum_nxt    : same for the ballots about to be registered
module ballot_bank #(
  parameter int unsigned N     = 1,
  parameter int unsigned W     = 1,
  parameter int unsigned SUM_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             capture,
  input  logic [N-1:0]     votes,
  output logic [SUM_W-1:0] sum,
  output logic [SUM_W-1:0] sum_nxt
);

  logic [N-1:0] bal_q;
  logic [N-1:0] bal_d;

  function automatic int unsigned weigh(input logic [N-1:0] v);
    int unsigned c;
    c = 0;
    for (int i = 0; i < int'(N); i++) c += {31'd0, v[i]};
    return c * W;
  endfunction

  always_comb begin
    bal_d = bal_q;
    if (clear) begin
      bal_d = '0;
    end else if (capture) begin
`ifdef CHANGE_VOTE_EN
      bal_d = bal_q ^ votes;
`else
      bal_d = bal_q | votes;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) bal_q <= '0;
    else        bal_q <= bal_d;
  end

  assign sum     = SUM_W'(weigh(bal_q));
  // Lets the top register pass on the closing edge including close-cycle votes.
  assign sum_nxt = SUM_W'(weigh(bal_d));

endmodule

// File: rtl/weighted_ballot_counter.sv
// Weighted ballot counter: three voter classes, session FSM and threshold
// pass decision. Optional build macro: CHANGE_VOTE_EN (toggle-vote mode).
//   clk   : rising-edge clock
//   reset : synchronous active-low reset
//   bus   : ballot bus (slave) - start/close/np/vip/vvip in,
//           result/open/decided/pass out
//
// state     | meaning
// ST_IDLE   | after reset, no session yet; votes ignored
// ST_OPEN   | session running; ballots captured every cycle
// ST_CLOSED | session ended; ballots frozen, pass held
module weighted_ballot_counter
  import weighted_ballot_counter_pkg::*;
#(
  parameter int unsigned N_NP   = DEF_N_NP,
  parameter int unsigned N_VIP  = DEF_N_VIP,
  parameter int unsigned N_VVIP = DEF_N_VVIP,
  parameter int unsigned W_NP   = DEF_W_NP,
  parameter int unsigned W_VIP  = DEF_W_VIP,
  parameter int unsigned W_VVIP = DEF_W_VVIP,
  parameter int unsigned RES_W  = DEF_RES_W,
  parameter int unsigned THRESH = DEF_THRESH
) (
  input logic                     clk,
  input logic                     reset,
  weighted_ballot_counter_if.slave bus
);

  localparam int unsigned MAX_TOTAL = N_NP * W_NP + N_VIP * W_VIP + N_VVIP * W_VVIP;
  localparam int unsigned SUM_W     = $clog2(MAX_TOTAL) + 1;
  localparam int unsigned RES_MAX   = (2 ** RES_W) - 1;

  state_t state_q, state_d;
  logic   clear, capture, load_pass, clr_pass;
  logic   pass_q;

  logic [SUM_W-1:0] np_sum, np_nxt, vip_sum, vip_nxt, vvip_sum, vvip_nxt;
  int unsigned      total_q, total_nxt;

  always_ff @(posedge clk) begin
    if (!reset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    clear     = 1'b0;
    capture   = 1'b0;
    load_pass = 1'b0;
    clr_pass  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          state_d = ST_OPEN;
          clear   = 1'b1;
        end
      end
      ST_OPEN: begin
        // Close-cycle votes still count; start is ignored here.
        capture = 1'b1;
        if (bus.close) begin
          state_d   = ST_CLOSED;
          load_pass = 1'b1;
        end
      end
      ST_CLOSED: begin
        if (bus.start) begin
          state_d  = ST_OPEN;
          clear    = 1'b1;
          clr_pass = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  ballot_bank #(.N(N_NP), .W(W_NP), .SUM_W(SUM_W)) u_np (
    .clk(clk), .reset(reset), .clear(clear), .capture(capture),
    .votes(bus.np), .sum(np_sum), .sum_nxt(np_nxt)
  );

  ballot_bank #(.N(N_VIP), .W(W_VIP), .SUM_W(SUM_W)) u_vip (
    .clk(clk), .reset(reset), .clear(clear), .capture(capture),
    .votes(bus.vip), .sum(vip_sum), .sum_nxt(vip_nxt)
  );

  ballot_bank #(.N(N_VVIP), .W(W_VVIP), .SUM_W(SUM_W)) u_vvip (
    .clk(clk), .reset(reset), .clear(clear), .capture(capture),
    .votes(bus.vvip), .sum(vvip_sum), .sum_nxt(vvip_nxt)
  );

  // SUM_W covers the full unsaturated total, so the first add cannot wrap;
  // clamping happens only on the final add.
  always_comb begin
    total_q   = sat_add(32'(np_sum) + 32'(vip_sum), 32'(vvip_sum), RES_MAX);
    total_nxt = sat_add(32'(np_nxt) + 32'(vip_nxt), 32'(vvip_nxt), RES_MAX);
  end

  always_ff @(posedge clk) begin
    if (!reset)         pass_q <= 1'b0;
    else if (clr_pass)  pass_q <= 1'b0;
    else if (load_pass) pass_q <= (total_nxt >= THRESH);
  end

  assign bus.result  = RES_W'(total_q);
  assign bus.open    = (state_q == ST_OPEN);
  assign bus.decided = (state_q == ST_CLOSED);
  assign bus.pass    = pass_q;

endmodule

// File: tb/tb_weighted_ballot_counter.sv
module tb_weighted_ballot_counter;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_fail;

  weighted_ballot_counter_if #(.RES_W(8)) bus8 ();
  weighted_ballot_counter_if #(.RES_W(5)) bus5 ();

  weighted_ballot_counter #(.RES_W(8)) dut8 (.clk(clk), .reset(reset), .bus(bus8));
  weighted_ballot_counter #(.RES_W(5)) dut5 (.clk(clk), .reset(reset), .bus(bus5));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: ballots as plain vectors, session as two flags.
  bit [31:0] m_np;
  bit [7:0]  m_vip;
  bit        m_vvip;
  bit        m_open, m_decided, m_pass8, m_pass5;

  function automatic int unsigned raw_total();
    return 32'($countones(m_np)) * 1 + 32'($countones(m_vip)) * 4 + 32'(m_vvip) * 16;
  endfunction

  function automatic int unsigned clamp(input int unsigned v, input int unsigned lim);
    return (v > lim) ? lim : v;
  endfunction

  task automatic chk(input string tag, input int unsigned got, input int unsigned exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic check_all();
    chk("result8",  32'(bus8.result),  clamp(raw_total(), 255));
    chk("result5",  32'(bus5.result),  clamp(raw_total(), 31));
    chk("open",     32'(bus8.open),    32'(m_open));
    chk("decided",  32'(bus8.decided), 32'(m_decided));
    chk("pass8",    32'(bus8.pass),    32'(m_pass8));
    chk("pass5",    32'(bus5.pass),    32'(m_pass5));
    chk("open5",    32'(bus5.open),    32'(m_open));
  endtask

  task automatic cycle(input bit rst_n, input bit st, input bit cl,
                       input bit [31:0] np, input bit [7:0] vip, input bit vvip);
    reset      = rst_n;
    bus8.start = st;  bus5.start = st;
    bus8.close = cl;  bus5.close = cl;
    bus8.np    = np;  bus5.np    = np;
    bus8.vip   = vip; bus5.vip   = vip;
    bus8.vvip  = vvip; bus5.vvip = vvip;
    @(posedge clk);
    if (!rst_n) begin
      m_np = '0; m_vip = '0; m_vvip = 1'b0;
      m_open = 1'b0; m_decided = 1'b0; m_pass8 = 1'b0; m_pass5 = 1'b0;
    end else if (m_open) begin
`ifdef CHANGE_VOTE_EN
      m_np ^= np; m_vip ^= vip; m_vvip ^= vvip;
`else
      m_np |= np; m_vip |= vip; m_vvip |= vvip;
`endif
      if (cl) begin
        m_open = 1'b0; m_decided = 1'b1;
        m_pass8 = clamp(raw_total(), 255) >= 41;
        m_pass5 = clamp(raw_total(), 31) >= 41;
      end
    end else if (st) begin
      m_open = 1'b1; m_decided = 1'b0;
      m_np = '0; m_vip = '0; m_vvip = 1'b0;
      m_pass8 = 1'b0; m_pass5 = 1'b0;
    end
    #1;
    check_all();
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    @(negedge clk);

    // Reset dominates start and votes.
    cycle(0, 1, 0, '1, '1, 1);
    cycle(0, 1, 0, '1, '1, 1);
    chk("rst_result", 32'(bus8.result), 0);

    cycle(1, 1, 0, 0, 0, 0);
    cycle(1, 0, 0, 32'h88888888, 8'h88, 1);
    chk("tc2_result", 32'(bus8.result), 32);
    cycle(1, 0, 0, 0, 0, 0);
    chk("tc2_hold", 32'(bus8.result), 32);
    cycle(1, 0, 0, 32'h88888888, 8'h88, 1);
`ifndef CHANGE_VOTE_EN
    chk("sticky_repeat", 32'(bus8.result), 32);
    cycle(1, 0, 0, 32'h00000001, 0, 0);
    chk("sticky_add", 32'(bus8.result), 33);
    cycle(1, 0, 1, 0, 0, 0);
    chk("close33_pass", 32'(bus8.pass), 0);
    cycle(1, 1, 0, 0, 0, 0);
    cycle(1, 0, 0, 32'h88888888, 8'h88, 1);
    cycle(1, 0, 1, 0, 8'h03, 0);
    chk("close40_res", 32'(bus8.result), 40);
    chk("close40_pass", 32'(bus8.pass), 0);
    cycle(1, 1, 0, 0, 0, 0);
    cycle(1, 0, 0, 32'h88888888, 8'h88, 1);
    cycle(1, 0, 1, 0, 8'h07, 0);
    chk("close44_res", 32'(bus8.result), 44);
    chk("close44_pass", 32'(bus8.pass), 1);
    cycle(1, 0, 0, '1, '1, 1);
    chk("closed_frozen", 32'(bus8.result), 44);
    cycle(1, 1, 0, 0, 0, 0);
    chk("restart_res", 32'(bus8.result), 0);
    chk("restart_pass", 32'(bus8.pass), 0);
`else
    chk("toggle_withdraw", 32'(bus8.result), 0);
    cycle(1, 0, 0, 0, 0, 1);
    chk("toggle_vvip", 32'(bus8.result), 16);
    cycle(1, 1, 1, 0, 0, 0);
    chk("start_close_decided", 32'(bus8.decided), 1);
`endif

    // Saturation: everyone votes.
    cycle(1, 0, 1, 0, 0, 0);
    cycle(1, 1, 0, 0, 0, 0);
    cycle(1, 0, 0, '1, '1, 1);
    chk("sat5", 32'(bus5.result), 31);
    chk("full8", 32'(bus8.result), 80);
    cycle(1, 0, 1, 0, 0, 0);
    chk("sat_pass8", 32'(bus8.pass), 1);
    cycle(1, 1, 0, 0, 0, 0);
    chk("sat_restart_open", 32'(bus5.open), 1);

    // Randomized sessions against the model.
    for (int i = 0; i < 800; i++) begin
      bit rst_n, st, cl, vv;
      bit [31:0] np;
      bit [7:0]  vip;
      rst_n = ($urandom_range(0, 63) != 0);
      st    = ($urandom_range(0, 9) == 0);
      cl    = ($urandom_range(0, 13) == 0);
      np    = $urandom & $urandom & $urandom;
      vip   = 8'($urandom & $urandom);
      vv    = ($urandom_range(0, 7) == 0);
      cycle(rst_n, st, cl, np, vip, vv);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
